// File: rtl/op_sequencer_if.sv
// Stream and controller-side signal bundle for op_sequencer.
// The master side is the command/data source that also stands in for the matrix controller.
interface op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        ctrl_enable;
  logic [31:0] ctrl_operation;
  logic [31:0] ctrl_in_data;
  logic [31:0] ctrl_out_data;

  modport master (
    output cmd_valid, cmd_data, wr_valid, wr_data, ctrl_out_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  ctrl_enable, ctrl_operation, ctrl_in_data
  );

  modport slave (
    input  cmd_valid, cmd_data, wr_valid, wr_data, ctrl_out_data,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output ctrl_enable, ctrl_operation, ctrl_in_data
  );
endinterface

// File: rtl/op_sequencer.sv
// Queues operation words and drives the matrix controller, holding each opcode
// for its required cycle count and moving write/read element streams.
module op_sequencer #(
  parameter int DEPTH = 4,
  parameter int DRAIN = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [8:0]   size,
  op_sequencer_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_MULT,
    ST_READ,
    ST_GAP
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        run_reg;
  logic [15:0] cnt_reg, cnt_next;
  logic [31:0] op_reg, op_next;
  logic        err_reg, err_next;
  logic        rd_valid_reg;
  logic [31:0] rd_data_reg;

  logic        fifo_empty, fifo_full, push, pop;
  logic [31:0] head_word;
  logic        wr_beat;
  logic [15:0] line_count, cell_count, elem_count, feed_count, mult_len;

  assign line_count = 16'(size[8:6]) + 16'd1;
  assign cell_count = 16'(size[5:0]) + 16'd1;
  assign elem_count = cell_count * line_count;
  assign feed_count = elem_count * line_count;
  assign mult_len   = feed_count + 16'(DRAIN);

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head_word  = fifo_mem[rd_ptr_reg[AW-1:0]];

  assign bus.cmd_ready = run_reg && !fifo_full;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign wr_beat       = (state_reg == ST_WRITE) && bus.wr_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.cmd_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    err_next   = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      ST_WRITE: begin
        if (wr_beat) begin
          if (cnt_reg == elem_count - 16'd1) begin
            state_next = ST_GAP;
            op_next    = 32'd0;
            cnt_next   = 16'd0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      ST_MULT: begin
        if (cnt_reg == mult_len - 16'd1) begin
          state_next = ST_GAP;
          op_next    = 32'd0;
          cnt_next   = 16'd0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_READ: begin
        if (cnt_reg == elem_count - 16'd1) begin
          state_next = ST_GAP;
          op_next    = 32'd0;
          cnt_next   = 16'd0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        // IDLE and GAP share the pop rule; GAP's zero opcode lasts exactly one cycle.
        state_next = ST_IDLE;
        op_next    = 32'd0;
        cnt_next   = 16'd0;
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_word[3:0])
            4'd1: begin
              state_next = ST_MULT;
              op_next    = head_word;
            end
            4'd2: begin
              state_next = ST_WRITE;
              op_next    = head_word;
            end
            4'd3: begin
              state_next = ST_READ;
              op_next    = head_word;
            end
            default: err_next = 1'b1;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      run_reg      <= 1'b0;
      cnt_reg      <= 16'd0;
      op_reg       <= 32'd0;
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= 32'd0;
    end else begin
      state_reg    <= state_next;
      run_reg      <= 1'b1;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      err_reg      <= err_next;
      rd_valid_reg <= (state_reg == ST_READ);
      if (state_reg == ST_READ) begin
        rd_data_reg <= bus.ctrl_out_data;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign bus.wr_ready       = wr_beat;
  assign bus.ctrl_enable    = run_reg && ((state_reg == ST_WRITE) ? bus.wr_valid : 1'b1);
  assign bus.ctrl_in_data   = (state_reg == ST_WRITE) ? bus.wr_data : 32'd0;
  assign bus.ctrl_operation = op_reg;
  assign bus.rd_valid       = rd_valid_reg;
  assign bus.rd_data        = rd_data_reg;

  assign busy = (state_reg != ST_IDLE) || !fifo_empty;
  assign done = (state_reg == ST_GAP);
  assign err  = err_reg;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: stimulus queues expected responses,
// a negedge monitor pops and compares them as the DUT produces output.
module tb_op_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] size;
  logic       busy, done, err;

  op_sequencer_if bus ();

  op_sequencer #(.DEPTH(4), .DRAIN(24)) dut (
    .clk  (clk),
    .reset(reset),
    .size (size),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] done_q[$];
  int          mult_q[$];
  int          err_q[$];

  // Controller model: returns 100+k on read issue cycle k.
  int rd_k = 0;
  always @(posedge clk)
    rd_k <= (bus.ctrl_enable && bus.ctrl_operation[3:0] == 4'd3) ? rd_k + 1 : 0;
  assign bus.ctrl_out_data = 32'd100 + 32'(rd_k);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor / scoreboard
  int          run_len = 0;
  int          b2b_count = 0;
  logic [31:0] prev_op = 0;
  logic [31:0] prev2_op = 0;

  always @(negedge clk) begin
    if (!reset) begin
      run_len  = 0;
      prev_op  = 0;
      prev2_op = 0;
    end else begin
      if (bus.wr_valid && bus.wr_ready) begin
        if (wr_q.size() == 0) fail_now("wr beat unexpected");
        else begin
          check("wr beat data", bus.ctrl_in_data, wr_q.pop_front());
          check("wr beat enable", {31'd0, bus.ctrl_enable}, 32'd1);
        end
      end
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) fail_now("rd beat unexpected");
        else check("rd beat data", bus.rd_data, rd_q.pop_front());
      end
      if (err) begin
        if (err_q.size() == 0) fail_now("err unexpected");
        else void'(err_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) fail_now("done unexpected");
        else check("done opcode", {28'd0, prev_op[3:0]}, done_q.pop_front());
        if (prev_op[3:0] == 4'd3) check("last rd beat on done", {31'd0, bus.rd_valid}, 32'd1);
      end
      if (bus.ctrl_operation == 32'd1) begin
        run_len++;
        if (prev_op == 32'd0 && prev2_op == 32'd1) b2b_count++;
      end else if (run_len > 0) begin
        if (mult_q.size() == 0) fail_now("mult run unexpected");
        else check("mult length", 32'(run_len), 32'(mult_q.pop_front()));
        check("gap opcode", bus.ctrl_operation, 32'd0);
        check("gap done", {31'd0, done}, 32'd1);
        run_len = 0;
      end
      prev2_op = prev_op;
      prev_op  = bus.ctrl_operation;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input logic [31:0] w, output int waited);
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      waited++;
      if (waited > 300) begin
        fail_now("cmd accept timeout");
        break;
      end
    end
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 300) begin
        fail_now("done timeout");
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 1000) begin
        fail_now("idle timeout");
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    size          = 9'b001_000011;  // L=2, C=4, E=8, F=16
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 32'd1;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 32'd0;

    // Reset held with a command offered
    repeat (2) @(negedge clk);
    check("rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst ctrl_enable", {31'd0, bus.ctrl_enable}, 32'd0);
    check("rst ctrl_operation", bus.ctrl_operation, 32'd0);
    check("rst busy/done/err/rd_valid", {28'd0, busy, done, err, bus.rd_valid}, 32'd0);
    step();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post-rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("post-rst ctrl_enable", {31'd0, bus.ctrl_enable}, 32'd1);
    check("post-rst op/busy", {bus.ctrl_operation[30:0], busy}, 32'd0);
    step();

    // Write: E=8 beats with wr_valid low every other cycle
    for (int i = 1; i <= 8; i++) wr_q.push_back(32'(i));
    done_q.push_back(32'd2);
    send_cmd(32'h0000_0002, w);
    for (int i = 1; i <= 8; i++) begin
      bus.wr_valid = 1'b0;
      @(negedge clk);
      if (i > 1) check("wr stall enable", {31'd0, bus.ctrl_enable}, 32'd0);
      step();
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'(i);
      step();
    end
    bus.wr_data = 32'd99;
    @(negedge clk);
    check("wr_ready after last beat", {31'd0, bus.wr_ready}, 32'd0);
    check("ctrl_in_data after write", bus.ctrl_in_data, 32'd0);
    step();
    bus.wr_valid = 1'b0;
    wait_idle();
    step();

    // Multiply: 16+24 cycles of opcode 1, first execute two cycles after offer
    mult_q.push_back(40);
    done_q.push_back(32'd1);
    send_cmd(32'h0000_0001, w);
    @(negedge clk);
    check("mult pop cycle op", bus.ctrl_operation, 32'd0);
    @(negedge clk);
    check("mult first execute op", bus.ctrl_operation, 32'd1);
    wait_done();
    @(negedge clk);
    check("busy after mult", {31'd0, busy}, 32'd0);
    step();

    // Read: 8 beats of 100..107
    for (int k = 0; k < 8; k++) rd_q.push_back(32'(100 + k));
    done_q.push_back(32'd3);
    send_cmd(32'h0000_0013, w);
    wait_done();
    @(negedge clk);
    check("busy after read", {31'd0, busy}, 32'd0);
    step();

    // Queue: five commands offered during a multiply, illegal opcode among them
    repeat (4) mult_q.push_back(40);
    done_q.push_back(32'd1);
    done_q.push_back(32'd1);
    done_q.push_back(32'd1);
    done_q.push_back(32'd3);
    done_q.push_back(32'd1);
    err_q.push_back(1);
    for (int k = 0; k < 8; k++) rd_q.push_back(32'(100 + k));
    send_cmd(32'h0000_0001, w);
    repeat (5) step();
    send_cmd(32'h0000_0001, w);
    send_cmd(32'h0000_0001, w);
    send_cmd(32'h0000_0005, w);
    send_cmd(32'h0000_0013, w);
    @(negedge clk);
    check("cmd_ready when full", {31'd0, bus.cmd_ready}, 32'd0);
    step();
    send_cmd(32'h0000_0001, w);
    check("5th cmd waited for pop", {31'd0, (w >= 10)}, 32'd1);
    wait_idle();
    step();

    // Abort: reset mid-multiply with a second multiply queued
    send_cmd(32'h0000_0001, w);
    send_cmd(32'h0000_0001, w);
    repeat (10) step();
    #2 reset = 1'b0;
    #1;
    check("abort ctrl_operation", bus.ctrl_operation, 32'd0);
    check("abort enable/ready/busy", {29'd0, bus.ctrl_enable, bus.cmd_ready, busy}, 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("abort fifo empty", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("abort nothing runs", {bus.ctrl_operation[30:0], busy}, 32'd0);

    check("back-to-back mult gaps", 32'(b2b_count), 32'd2);
    check("queues drained", 32'(wr_q.size() + rd_q.size() + done_q.size() + mult_q.size() + err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
